// File: rtl/unpack_pkg.sv
// rtl/unpack_pkg.sv - shared state encoding and index sizing for unpack_stream
package unpack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of the element index; depth 1 still needs one bit to name an index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/unpack_stream.sv
// rtl/unpack_stream.sv - unpacks ARGD-element argument words into one element per cycle
// Optional per-argument element count via UNPACK_STREAM_CNT_EN (adds arg_cnt port).
module unpack_stream
  import unpack_pkg::*;
#(
  parameter int ARGW      = 8,
  parameter int ARGD      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arg_stb,
  input  logic [ARGD*ARGW-1:0]   arg_dat,
`ifdef UNPACK_STREAM_CNT_EN
  input  logic [$clog2(ARGD)-1:0] arg_cnt,
`endif
  output logic                   arg_rdy,
  output logic                   out_stb,
  output logic [ARGW-1:0]        out_dat,
  output logic                   out_lst,
  input  logic                   out_rdy
);

  localparam int IW = idx_width(ARGD);
  localparam logic [IW-1:0] LAST_FULL = IW'(ARGD - 1);

  state_t                 state;
  logic [ARGD*ARGW-1:0]   data_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_nxt;
  logic [IW-1:0]          last_now;
  logic [IW-1:0]          last_new;
  logic                   arg_fire;
  logic                   out_fire;

  // Maps a logical emission index onto the physical element slot.
  function automatic logic [ARGW-1:0] elem(input logic [ARGD*ARGW-1:0] w,
                                           input logic [IW-1:0] i);
    logic [IW-1:0] p;
    p = (MSB_FIRST != 0) ? (LAST_FULL - i) : i;
    return w[p*ARGW +: ARGW];
  endfunction

`ifdef UNPACK_STREAM_CNT_EN
  logic [IW-1:0] last_q;

  always_comb begin
    last_new = arg_cnt;
    if (int'(arg_cnt) > ARGD - 1) last_new = LAST_FULL;
  end
  assign last_now = last_q;
`else
  assign last_new = LAST_FULL;
  assign last_now = LAST_FULL;
`endif

  assign arg_rdy  = (state == IDLE) | (out_stb & out_rdy & out_lst);
  assign arg_fire = arg_stb & arg_rdy;
  assign out_fire = out_stb & out_rdy;
  assign idx_nxt  = idx_q + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      out_stb <= 1'b0;
      out_dat <= '0;
      out_lst <= 1'b0;
`ifdef UNPACK_STREAM_CNT_EN
      last_q  <= '0;
`endif
    end else if (arg_fire) begin
      // Covers both the idle accept and the no-bubble reload on the last element.
      state   <= BUSY;
      data_q  <= arg_dat;
      idx_q   <= '0;
      out_stb <= 1'b1;
      out_dat <= elem(arg_dat, '0);
      out_lst <= (last_new == '0);
`ifdef UNPACK_STREAM_CNT_EN
      last_q  <= last_new;
`endif
    end else if (out_fire) begin
      if (out_lst) begin
        state   <= IDLE;
        out_stb <= 1'b0;
        out_lst <= 1'b0;
      end else begin
        idx_q   <= idx_nxt;
        out_dat <= elem(data_q, idx_nxt);
        out_lst <= (idx_nxt == last_now);
      end
    end
  end

endmodule

// File: tb/tb_unpack_stream.sv
// tb/tb_unpack_stream.sv - directed bench for unpack_stream, LSB-first and MSB-first instances
module tb_unpack_stream;

  logic        clk;
  logic        rst_n;
  logic        arg_stb;
  logic [31:0] arg_dat;
  logic        out_rdy;
`ifdef UNPACK_STREAM_CNT_EN
  logic [1:0]  arg_cnt;
`endif

  logic        arg_rdy0, out_stb0, out_lst0;
  logic [7:0]  out_dat0;
  logic        arg_rdy1, out_stb1, out_lst1;
  logic [7:0]  out_dat1;

  int checks;
  int failures;

  logic [7:0] t1_e0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t1_e1 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] t3_e0 [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] t3_e1 [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] t6_e0 [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] t6_e1 [4] = '{8'h88, 8'h77, 8'h66, 8'h55};

  unpack_stream #(.ARGW(8), .ARGD(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .arg_stb(arg_stb), .arg_dat(arg_dat),
`ifdef UNPACK_STREAM_CNT_EN
    .arg_cnt(arg_cnt),
`endif
    .arg_rdy(arg_rdy0), .out_stb(out_stb0), .out_dat(out_dat0),
    .out_lst(out_lst0), .out_rdy(out_rdy)
  );

  unpack_stream #(.ARGW(8), .ARGD(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .arg_stb(arg_stb), .arg_dat(arg_dat),
`ifdef UNPACK_STREAM_CNT_EN
    .arg_cnt(arg_cnt),
`endif
    .arg_rdy(arg_rdy1), .out_stb(out_stb1), .out_dat(out_dat1),
    .out_lst(out_lst1), .out_rdy(out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_el(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                        input logic lst, input logic rdy);
    chk({tag, " stb0"}, 32'(out_stb0), 32'd1);
    chk({tag, " stb1"}, 32'(out_stb1), 32'd1);
    chk({tag, " dat0"}, 32'(out_dat0), 32'(d0));
    chk({tag, " dat1"}, 32'(out_dat1), 32'(d1));
    chk({tag, " lst0"}, 32'(out_lst0), 32'(lst));
    chk({tag, " lst1"}, 32'(out_lst1), 32'(lst));
    chk({tag, " rdy0"}, 32'(arg_rdy0), 32'(rdy));
    chk({tag, " rdy1"}, 32'(arg_rdy1), 32'(rdy));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " stb0"}, 32'(out_stb0), 32'd0);
    chk({tag, " stb1"}, 32'(out_stb1), 32'd0);
    chk({tag, " lst0"}, 32'(out_lst0), 32'd0);
    chk({tag, " lst1"}, 32'(out_lst1), 32'd0);
    chk({tag, " rdy0"}, 32'(arg_rdy0), 32'd1);
    chk({tag, " rdy1"}, 32'(arg_rdy1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    arg_stb  = 1'b0;
    arg_dat  = 32'h0;
    out_rdy  = 1'b1;
`ifdef UNPACK_STREAM_CNT_EN
    arg_cnt  = 2'd3;
`endif

    // Reset state
    tick();
    chk_idle("reset");
    chk("reset dat0", 32'(out_dat0), 32'h0);
    chk("reset dat1", 32'(out_dat1), 32'h0);
    rst_n = 1'b1;

    // Single argument, free-flowing sink
    arg_stb = 1'b1;
    arg_dat = 32'h44332211;
    @(negedge clk);
    chk_idle("t1 pre");
    tick();
    arg_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_el($sformatf("t1 e%0d", k), t1_e0[k], t1_e1[k], k == 3, k == 3);
      tick();
    end
    @(negedge clk);
    chk_idle("t1 post");

    // Back-to-back arguments with arg_stb held; data changes while busy
    tick();
    arg_stb = 1'b1;
    arg_dat = 32'hDDCCBBAA;
    @(negedge clk);
    chk_idle("t3 pre");
    tick();
    arg_dat = 32'h04030201;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_el($sformatf("t3 e%0d", k), t3_e0[k], t3_e1[k], (k % 4) == 3, (k % 4) == 3);
      tick();
      if (k == 3) arg_stb = 1'b0;
    end
    @(negedge clk);
    chk_idle("t3 post");

    // Sink stall on element 2 with a competing argument offered
    tick();
    arg_stb = 1'b1;
    arg_dat = 32'h44332211;
    tick();
    arg_stb = 1'b0;
    @(negedge clk);
    chk_el("t4 e0", 8'h11, 8'h44, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_el("t4 e1", 8'h22, 8'h33, 1'b0, 1'b0);
    tick();
    out_rdy = 1'b0;
    arg_stb = 1'b1;
    arg_dat = 32'hEEEEEEEE;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_el($sformatf("t4 stall%0d", s), 8'h33, 8'h22, 1'b0, 1'b0);
      tick();
    end
    out_rdy = 1'b1;
    arg_stb = 1'b0;
    @(negedge clk);
    chk_el("t4 e2", 8'h33, 8'h22, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_el("t4 e3", 8'h44, 8'h11, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk_idle("t4 post");

    // Asynchronous reset mid-argument, then a clean restart
    tick();
    arg_stb = 1'b1;
    arg_dat = 32'h44332211;
    tick();
    arg_stb = 1'b0;
    @(negedge clk);
    chk_el("t6 e0", 8'h11, 8'h44, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_el("t6 e1", 8'h22, 8'h33, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("t6 rst");
    chk("t6 rst dat0", 32'(out_dat0), 32'h0);
    chk("t6 rst dat1", 32'(out_dat1), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    arg_stb = 1'b1;
    arg_dat = 32'h88776655;
    tick();
    arg_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_el($sformatf("t6 n%0d", k), t6_e0[k], t6_e1[k], k == 3, k == 3);
      tick();
    end
    @(negedge clk);
    chk_idle("t6 post");

`ifdef UNPACK_STREAM_CNT_EN
    // Two-element argument; arg_cnt changes after accept and must be ignored
    tick();
    arg_cnt = 2'd1;
    arg_stb = 1'b1;
    arg_dat = 32'h44332211;
    tick();
    arg_stb = 1'b0;
    arg_cnt = 2'd3;
    @(negedge clk);
    chk_el("t5 c1 e0", 8'h11, 8'h44, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk_el("t5 c1 e1", 8'h22, 8'h33, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    chk_idle("t5 c1 post");

    tick();
    arg_stb = 1'b1;
    tick();
    arg_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_el($sformatf("t5 c3 e%0d", k), t1_e0[k], t1_e1[k], k == 3, k == 3);
      tick();
    end
    @(negedge clk);
    chk_idle("t5 c3 post");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpack_stream.md
UNPACK_STREAM -- requirements
Module: unpack_stream

Interface
REQ-001 SHALL have parameter ARGW, default 8, meaning element width in bits (>=1).
REQ-002 SHALL have parameter ARGD, default 4, meaning elements per argument word (>=2).
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning 0 emits element 0 (bits ARGW-1:0) first and 1 emits element ARGD-1 first.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port arg_stb, input, 1, argument word valid.
REQ-007 SHALL have port arg_dat, input, ARGD*ARGW, packed argument word.
REQ-008 SHALL have port arg_cnt, input, $clog2(ARGD), element count minus one; present only when UNPACK_STREAM_CNT_EN is defined.
REQ-009 SHALL have port arg_rdy, output, 1, argument accept.
REQ-010 SHALL have port out_stb, output, 1, element valid (registered).
REQ-011 SHALL have port out_dat, output, ARGW, element data (registered).
REQ-012 SHALL have port out_lst, output, 1, high on the final element of an argument (registered).
REQ-013 SHALL have port out_rdy, input, 1, element accept.

Function
REQ-014 SHALL transfer an argument on arg_stb & arg_rdy and an element on out_stb & out_rdy.
REQ-015 SHALL implement two states: IDLE (no argument held) and BUSY (argument held, elements pending).
REQ-016 SHALL drive arg_rdy = IDLE | (out_stb & out_rdy & out_lst), combinationally, with no arg_stb -> arg_rdy path.
REQ-017 SHALL, on argument accept, register arg_dat and the element count, go to BUSY, and present the first element with out_stb=1 on the next cycle; latency is 1 cycle.
REQ-018 SHALL advance to the next element in the configured order on each element handshake that is not last.
REQ-019 SHALL hold out_stb, out_dat and out_lst stable while out_stb & ~out_rdy.
REQ-020 SHALL assert out_lst only on element N-1 of N, where N = arg_cnt+1 (or ARGD).
REQ-021 SHALL, on last-element handshake with arg_stb high, accept the new argument in the same cycle and present its first element next cycle, with no bubble (one element per cycle sustained).
REQ-022 SHALL, on last-element handshake with arg_stb low, return to IDLE and drop out_stb next cycle.
REQ-023 SHALL clamp arg_cnt values above ARGD-1 to ARGD-1.
REQ-024 SHALL ignore arg_dat and arg_cnt when no argument handshake occurs.

Reset
REQ-025 SHALL, on rst_n low, immediately force IDLE, out_stb=0, out_lst=0, out_dat=0, index=0, discarding any held argument.
REQ-026 SHALL hold arg_rdy=1 after reset release (IDLE).

Configuration
REQ-027 SHALL, with UNPACK_STREAM_CNT_EN defined, provide arg_cnt and emit arg_cnt+1 elements per argument.
REQ-028 SHALL, without UNPACK_STREAM_CNT_EN, omit arg_cnt, emit exactly ARGD elements per argument, and remove count registers and comparators.

Structure
REQ-029 SHALL place the state enum (IDLE, BUSY) and an index-width function ($clog2 of ARGD) in shared package unpack_pkg.
REQ-030 SHALL be a single flat module with no sub-module.

Verification (ARGW=8, ARGD=4)
REQ-031 SHALL check that, with MSB_FIRST=0, out_rdy=1 and arg 0x44332211 -> out 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_lst only on 0x44.
REQ-032 SHALL check that, with MSB_FIRST=1, arg 0x44332211 -> out 0x44,0x33,0x22,0x11.
REQ-033 SHALL check that back-to-back args 0xDDCCBBAA, 0x04030201 with arg_stb held -> 8 elements on 8 consecutive cycles, arg_rdy high only on cycles 0 and 4.
REQ-034 SHALL check that out_rdy low for 3 cycles on element 2 -> out_dat=0x33 held, out_stb=1, arg_rdy=0 throughout.
REQ-035 SHALL check that, with UNPACK_STREAM_CNT_EN, arg_cnt=1 and arg 0x44332211 -> out 0x11, 0x22(lst), then IDLE; arg_cnt=3 -> 4 elements.
REQ-036 SHALL check that rst_n pulsed low mid-argument after element 1 -> out_stb=0 asynchronously, and the next argument restarts at element 0.
